// File: rtl/raycast_pkg.sv
// Shared types and constants for the raycasting datapath: default frame
// geometry, the packed camera pose and the frame scheduler state encoding.
package raycast_pkg;

    localparam int NUM_RAYS = 320;
    localparam int HCOUNT_W = 9;
    localparam int POSE_W   = 16;

    // Whole camera pose in one packed word so a frame-start latch is a single register.
    typedef struct packed {
        logic [POSE_W-1:0] pos_x;
        logic [POSE_W-1:0] pos_y;
        logic [POSE_W-1:0] dir_x;
        logic [POSE_W-1:0] dir_y;
        logic [POSE_W-1:0] plane_x;
        logic [POSE_W-1:0] plane_y;
    } pose_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SWAP_WAIT
    } sched_state_e;

endpackage

// File: rtl/sched_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment restarts the count at 1, so the clearing cycle itself is counted.
module sched_sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Restart on clear, otherwise count up and hold at MAX.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Per-frame sequencer for the raycasting datapath. Latches the camera pose on
// frame start, issues column indices under valid/ready, counts finished
// columns and requests a frame-buffer swap on the following frame start.
// Optional statistics (overrun count, frame cycle count) are enabled by
// defining RAY_FRAME_SCHED_STATS_EN.
module ray_frame_scheduler #(
    parameter int NUM_RAYS = raycast_pkg::NUM_RAYS,
    parameter int HCOUNT_W = raycast_pkg::HCOUNT_W,
    parameter int POSE_W   = raycast_pkg::POSE_W    // must match the pose_t field width
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                new_frame_in,
    input  logic [POSE_W-1:0]   posX_in,
    input  logic [POSE_W-1:0]   posY_in,
    input  logic [POSE_W-1:0]   dirX_in,
    input  logic [POSE_W-1:0]   dirY_in,
    input  logic [POSE_W-1:0]   planeX_in,
    input  logic [POSE_W-1:0]   planeY_in,
    output logic [POSE_W-1:0]   posX_out,
    output logic [POSE_W-1:0]   posY_out,
    output logic [POSE_W-1:0]   dirX_out,
    output logic [POSE_W-1:0]   dirY_out,
    output logic [POSE_W-1:0]   planeX_out,
    output logic [POSE_W-1:0]   planeY_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic                hcount_valid_out,
    input  logic                hcount_ready_in,
    input  logic                ray_done_in,
    output logic                swap_out,
    output logic                busy_out,
    output logic                overrun_out
`ifdef RAY_FRAME_SCHED_STATS_EN
    ,
    output logic [7:0]          overrun_count_out,
    output logic [23:0]         frame_cycles_out
`endif
);

    import raycast_pkg::*;

    localparam int                  DONE_W      = $clog2(NUM_RAYS + 1);
    localparam logic [DONE_W-1:0]   DONE_MAX    = DONE_W'(NUM_RAYS);
    localparam logic [DONE_W-1:0]   DONE_LAST   = DONE_W'(NUM_RAYS - 1);
    localparam logic [HCOUNT_W-1:0] HCOUNT_LAST = HCOUNT_W'(NUM_RAYS - 1);

    sched_state_e        state;
    sched_state_e        state_next;
    pose_t               pose_q;
    logic [HCOUNT_W-1:0] hcount_q;
    logic [DONE_W-1:0]   done_cnt;
    logic                overrun_q;
    logic                frame_start;
    logic                overrun_event;
    logic                transfer;
    logic                last_col;
    logic                complete;

    assign transfer = (state == ISSUE) && hcount_ready_in;
    assign last_col = (hcount_q == HCOUNT_LAST);
    // Completion looks at the count including this cycle's pulse.
    assign complete = (state == DRAIN) &&
                      ((done_cnt == DONE_MAX) || ((done_cnt == DONE_LAST) && ray_done_in));

    // State register.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus frame-start and overrun strobes.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_next    = state;
        frame_start   = 1'b0;
        overrun_event = 1'b0;
        case (state)
            IDLE: begin
                if (new_frame_in) begin
                    frame_start = 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                overrun_event = new_frame_in;
                if (transfer && last_col) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (complete) begin
                    if (new_frame_in) begin
                        frame_start = 1'b1;
                        state_next  = ISSUE;
                    end else begin
                        state_next = SWAP_WAIT;
                    end
                end else begin
                    overrun_event = new_frame_in;
                end
            end
            SWAP_WAIT: begin
                if (new_frame_in) begin
                    frame_start = 1'b1;
                    state_next  = ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Column index: cleared on frame start, advanced on each non-final transfer.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_q <= '0;
        end else if (frame_start) begin
            hcount_q <= '0;
        end else if (transfer && !last_col) begin
            hcount_q <= hcount_q + HCOUNT_W'(1);
        end
    end

    // Pose snapshot taken only at frame start so a frame renders one consistent view.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            pose_q <= '0;
        end else if (frame_start) begin
            pose_q <= '{pos_x: posX_in, pos_y: posY_in, dir_x: dirX_in,
                        dir_y: dirY_in, plane_x: planeX_in, plane_y: planeY_in};
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            overrun_q <= 1'b0;
        end else if (overrun_event) begin
            overrun_q <= 1'b1;
        end
    end

    // Finished-column counter; a pulse arriving with the next frame start belongs to the old frame.
    sched_sat_counter #(
        .WIDTH (DONE_W),
        .MAX   (DONE_MAX)
    ) u_done_cnt (
        .clk   (pixel_clk_in),
        .rst   (rst_in),
        .clr   (frame_start),
        .inc   (ray_done_in && busy_out && !frame_start),
        .count (done_cnt)
    );

`ifdef RAY_FRAME_SCHED_STATS_EN
    logic [23:0] cycle_cnt;
    logic [23:0] frame_cycles_q;

    sched_sat_counter #(
        .WIDTH (8)
    ) u_overrun_cnt (
        .clk   (pixel_clk_in),
        .rst   (rst_in),
        .clr   (1'b0),
        .inc   (overrun_event),
        .count (overrun_count_out)
    );

    // Counts from the frame-start latch cycle up to (not including) the completion cycle.
    sched_sat_counter #(
        .WIDTH (24)
    ) u_cycle_cnt (
        .clk   (pixel_clk_in),
        .rst   (rst_in),
        .clr   (frame_start),
        .inc   (busy_out || frame_start),
        .count (cycle_cnt)
    );

    // Capture the frame duration when the drain completes.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            frame_cycles_q <= '0;
        end else if (complete) begin
            frame_cycles_q <= cycle_cnt;
        end
    end

    assign frame_cycles_out = frame_cycles_q;
`endif

    assign posX_out         = pose_q.pos_x;
    assign posY_out         = pose_q.pos_y;
    assign dirX_out         = pose_q.dir_x;
    assign dirY_out         = pose_q.dir_y;
    assign planeX_out       = pose_q.plane_x;
    assign planeY_out       = pose_q.plane_y;
    assign hcount_out       = hcount_q;
    assign hcount_valid_out = (state == ISSUE);
    assign busy_out         = (state == ISSUE) || (state == DRAIN);
    assign overrun_out      = overrun_q;
    // Swap only when a frame start closes a finished frame, never from IDLE.
    assign swap_out         = frame_start && (state != IDLE) && !rst_in;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Self-checking bench for ray_frame_scheduler: column indices are checked
// against a scoreboard queue filled at each frame start.
module tb_ray_frame_scheduler;

    localparam int N     = 320;
    localparam int HW    = 9;
    localparam int PW    = 16;
    localparam int BOUND = 2000;

    logic          clk = 1'b0;
    logic          rst_in, new_frame_in, hcount_ready_in, ray_done_in;
    logic [PW-1:0] posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in;
    logic [PW-1:0] posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out;
    logic [HW-1:0] hcount_out;
    logic          hcount_valid_out, swap_out, busy_out, overrun_out;
    logic [6*PW-1:0] pose_out;
    logic [6*PW-1:0] exp_pose;

    int errors = 0;
    int checks = 0;
    int n_xfer = 0;
    int n_swap = 0;
    logic [HW-1:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [HW-1:0] prev_h = '0;

    always #5 clk = ~clk;

    assign pose_out = {posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out};

    ray_frame_scheduler dut (
        .pixel_clk_in     (clk),
        .rst_in           (rst_in),
        .new_frame_in     (new_frame_in),
        .posX_in          (posX_in),
        .posY_in          (posY_in),
        .dirX_in          (dirX_in),
        .dirY_in          (dirY_in),
        .planeX_in        (planeX_in),
        .planeY_in        (planeY_in),
        .posX_out         (posX_out),
        .posY_out         (posY_out),
        .dirX_out         (dirX_out),
        .dirY_out         (dirY_out),
        .planeX_out       (planeX_out),
        .planeY_out       (planeY_out),
        .hcount_out       (hcount_out),
        .hcount_valid_out (hcount_valid_out),
        .hcount_ready_in  (hcount_ready_in),
        .ray_done_in      (ray_done_in),
        .swap_out         (swap_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out)
    );

    // One clock cycle: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [HW-1:0] exp_h;
        @(negedge clk);
        if (prev_stall) begin
            checks++;
            if (hcount_valid_out !== 1'b1 || hcount_out !== prev_h) begin
                errors++;
                $display("FAIL hold: valid=%b hcount=%0d, required valid=1 hcount=%0d",
                         hcount_valid_out, hcount_out, prev_h);
            end
        end
        if (hcount_valid_out === 1'b1 && hcount_ready_in === 1'b1) begin
            n_xfer++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: hcount=%0d, required no transfer", hcount_out);
            end else begin
                exp_h = exp_q.pop_front();
                if (hcount_out !== exp_h) begin
                    errors++;
                    $display("FAIL xfer_order: hcount=%0d, required %0d", hcount_out, exp_h);
                end
            end
        end
        if (swap_out === 1'b1) n_swap++;
        prev_stall = (hcount_valid_out === 1'b1) && (hcount_ready_in === 1'b0);
        prev_h     = hcount_out;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [PW-1:0] px, input bit push);
        posX_in   = px;
        posY_in   = px + 16'h0011;
        dirX_in   = px + 16'h0022;
        dirY_in   = px + 16'h0033;
        planeX_in = px + 16'h0044;
        planeY_in = px + 16'h0055;
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
        if (push) begin
            exp_pose = {posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in};
            for (int i = 0; i < N; i++) exp_q.push_back(HW'(i));
        end
    endtask

    task automatic send_done(input int n);
        ray_done_in = 1'b1;
        repeat (n) tick();
        ray_done_in = 1'b0;
    endtask

    // Run until the scoreboard empties; optional 1-0-1 back-pressure pattern.
    task automatic drain(input string name, input bit bp, output int cyc);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < BOUND) begin
            hcount_ready_in = bp ? ((cyc % 3) != 1) : 1'b1;
            tick();
            cyc++;
        end
        hcount_ready_in = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d columns outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; new_frame_in = 1'b0; hcount_ready_in = 1'b1; ray_done_in = 1'b0;
        posX_in = '0; posY_in = '0; dirX_in = '0; dirY_in = '0; planeX_in = '0; planeY_in = '0;
        tick(); tick();
        rst_in = 1'b0;
        checks++;
        if ({hcount_valid_out, swap_out, busy_out, overrun_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: valid/swap/busy/overrun=%b, required 0000",
                     {hcount_valid_out, swap_out, busy_out, overrun_out});
        end
        checks++;
        if (hcount_out !== '0 || pose_out !== '0) begin
            errors++;
            $display("FAIL reset_values: hcount=%0d pose=%h, required 0", hcount_out, pose_out);
        end
    endtask

    task automatic test_issue_stream();
        int cyc;
        start_frame(16'h0100, 1'b1);
        checks++;
        if (hcount_valid_out !== 1'b1 || hcount_out !== '0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL first_issue: valid=%b hcount=%0d busy=%b, required 1 0 1",
                     hcount_valid_out, hcount_out, busy_out);
        end
        checks++;
        if (pose_out !== exp_pose) begin
            errors++;
            $display("FAIL pose_latch: pose=%h, required %h", pose_out, exp_pose);
        end
        drain("stream", 1'b0, cyc);
        checks++;
        if (cyc != N) begin
            errors++;
            $display("FAIL stream_rate: %0d cycles, required %0d", cyc, N);
        end
        checks++;
        if (hcount_valid_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL drain_state: valid=%b busy=%b, required 0 1", hcount_valid_out, busy_out);
        end
    endtask

    task automatic test_pose_hold();
        posX_in = 16'h0200;
        repeat (3) tick();
        checks++;
        if (posX_out !== 16'h0100 || pose_out !== exp_pose) begin
            errors++;
            $display("FAIL pose_hold: posX=%h, required 0100", posX_out);
        end
    endtask

    task automatic test_swap();
        int sw0;
        send_done(N - 1);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL early_complete: busy=%b, required 1", busy_out);
        end
        send_done(1);
        checks++;
        if (busy_out !== 1'b0 || n_swap != 0) begin
            errors++;
            $display("FAIL swap_wait: busy=%b swaps=%0d, required 0 0", busy_out, n_swap);
        end
        sw0 = n_swap;
        start_frame(16'h0200, 1'b1);
        checks++;
        if (n_swap != sw0 + 1) begin
            errors++;
            $display("FAIL swap_pulse: swaps=%0d, required %0d", n_swap, sw0 + 1);
        end
        checks++;
        if (hcount_valid_out !== 1'b1 || hcount_out !== '0 || posX_out !== 16'h0200 ||
            pose_out !== exp_pose) begin
            errors++;
            $display("FAIL next_frame: valid=%b hcount=%0d posX=%h, required 1 0 0200",
                     hcount_valid_out, hcount_out, posX_out);
        end
        tick();
        checks++;
        if (n_swap != sw0 + 1) begin
            errors++;
            $display("FAIL swap_width: swaps=%0d, required %0d", n_swap, sw0 + 1);
        end
    endtask

    task automatic test_back_pressure();
        int cyc;
        int x0;
        x0 = n_xfer;
        drain("backpressure", 1'b1, cyc);
        checks++;
        if (n_xfer - x0 != N - 1) begin
            errors++;
            $display("FAIL bp_count: %0d transfers, required %0d", n_xfer - x0, N - 1);
        end
        checks++;
        if (hcount_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: valid=%b, required 0", hcount_valid_out);
        end
    endtask

    task automatic test_coincident();
        int sw0;
        int cyc;
        send_done(N - 1);
        sw0 = n_swap;
        ray_done_in = 1'b1;
        start_frame(16'h0300, 1'b1);
        ray_done_in = 1'b0;
        checks++;
        if (n_swap != sw0 + 1 || overrun_out !== 1'b0) begin
            errors++;
            $display("FAIL coincident: swaps=%0d overrun=%b, required %0d 0",
                     n_swap, overrun_out, sw0 + 1);
        end
        checks++;
        if (hcount_valid_out !== 1'b1 || hcount_out !== '0) begin
            errors++;
            $display("FAIL coincident_restart: valid=%b hcount=%0d, required 1 0",
                     hcount_valid_out, hcount_out);
        end
        drain("frame3", 1'b0, cyc);
    endtask

    task automatic test_overrun();
        int sw0;
        send_done(200);
        sw0 = n_swap;
        start_frame(16'h0400, 1'b0);
        checks++;
        if (overrun_out !== 1'b1 || n_swap != sw0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL overrun: overrun=%b swaps=%0d busy=%b, required 1 %0d 1",
                     overrun_out, n_swap, busy_out, sw0);
        end
        checks++;
        if (posX_out !== 16'h0300) begin
            errors++;
            $display("FAIL overrun_pose: posX=%h, required 0300", posX_out);
        end
        send_done(119);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain: busy=%b, required 1", busy_out);
        end
        send_done(1);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL overrun_complete: busy=%b, required 0", busy_out);
        end
        start_frame(16'h0400, 1'b1);
        checks++;
        if (n_swap != sw0 + 1 || overrun_out !== 1'b1) begin
            errors++;
            $display("FAIL deferred_swap: swaps=%0d overrun=%b, required %0d 1",
                     n_swap, overrun_out, sw0 + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int sw0;
        int cyc;
        cyc = 0;
        while (exp_q.size() > N - 150 && cyc < BOUND) begin
            tick();
            cyc++;
        end
        checks++;
        if (hcount_out !== HW'(150)) begin
            errors++;
            $display("FAIL mid_frame_index: hcount=%0d, required 150", hcount_out);
        end
        hcount_ready_in = 1'b0;
        rst_in = 1'b1;
        tick();
        checks++;
        if ({hcount_valid_out, swap_out, busy_out, overrun_out} !== 4'b0000 ||
            hcount_out !== '0 || pose_out !== '0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b hcount=%0d pose=%h, required all 0",
                     {hcount_valid_out, swap_out, busy_out, overrun_out}, hcount_out, pose_out);
        end
        rst_in = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        hcount_ready_in = 1'b1;
        send_done(5);
        sw0 = n_swap;
        start_frame(16'h0500, 1'b1);
        checks++;
        if (n_swap != sw0 || hcount_valid_out !== 1'b1 || hcount_out !== '0) begin
            errors++;
            $display("FAIL restart: swaps=%0d valid=%b hcount=%0d, required %0d 1 0",
                     n_swap, hcount_valid_out, hcount_out, sw0);
        end
        drain("restart", 1'b0, cyc);
        send_done(N - 1);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_pulses_counted: busy=%b, required 1", busy_out);
        end
        send_done(1);
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL restart_complete: busy=%b, required 0", busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_issue_stream();
        test_pose_hold();
        test_swap();
        test_back_pressure();
        test_coincident();
        test_overrun();
        test_reset_mid_frame();
        checks++;
        if (n_swap != 3) begin
            errors++;
            $display("FAIL swap_total: %0d swaps, required 3", n_swap);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
